// File: rtl/div_pkg.sv
// Shared encodings for the divider sequencing controller: op codes, FSM states
// and the operand key used by the result cache.
package div_pkg;
  localparam logic [1:0] OP_DIV_W  = 2'b00;
  localparam logic [1:0] OP_MOD_W  = 2'b01;
  localparam logic [1:0] OP_DIV_WU = 2'b10;
  localparam logic [1:0] OP_MOD_WU = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, DRAIN} div_state_t;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic        sgn;
  } div_key_t;
endpackage

// File: rtl/div_result_cache.sv
// Single-entry operand/result store; the DIV/MOD select is deliberately not part
// of the key so a DIV/MOD pair on the same operands shares one division.
module div_result_cache
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        invalidate,
  input  div_key_t    key,
  output logic        hit,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        valid,
  input  logic        upd,
  input  div_key_t    upd_key,
  input  logic [31:0] upd_q,
  input  logic [31:0] upd_r
);
  div_key_t ent_key;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      ent_key <= '0;
      q       <= '0;
      r       <= '0;
    end else if (invalidate) begin
      valid <= 1'b0;
    end else if (upd) begin
      valid   <= 1'b1;
      ent_key <= upd_key;
      q       <= upd_q;
      r       <= upd_r;
    end
  end

  assign hit = valid && (key == ent_key);
endmodule

// File: rtl/div_ctrl.sv
// EX-stage sequencer for the multi-cycle divider: request handshake, operand
// hold through completion, flush draining and quotient/remainder selection.
module div_ctrl
  import div_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  input  logic        flush,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  input  logic        div_busy,
  input  logic        div_done,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r
);
  div_state_t  state;
  logic        opnd_mod;
  logic        accept, hit, cache_hit, cache_upd;
  logic [31:0] cache_q, cache_r;
  logic        cache_valid;
  div_key_t    lookup_key, opnd_key;
  logic        unused_busy;

  // Launch only ever happens from IDLE, where the divider is already idle.
  assign unused_busy = div_busy;

  assign in_ready   = resetn && (state == IDLE) && !flush;
  assign accept     = in_valid && in_ready;
  assign lookup_key = '{x: in_x, y: in_y, sgn: ~in_op[1]};
  assign hit        = CACHE_EN && cache_hit;
  assign cache_upd  = div_done && ((state == WAIT) || (state == DRAIN));

  assign div_x      = opnd_key.x;
  assign div_y      = opnd_key.y;
  assign div_signed = opnd_key.sgn;

  div_result_cache u_cache (
    .clk       (clk),
    .rst_n     (resetn),
    .invalidate(!CACHE_EN),
    .key       (lookup_key),
    .hit       (cache_hit),
    .q         (cache_q),
    .r         (cache_r),
    .valid     (cache_valid),
    .upd       (cache_upd),
    .upd_key   (opnd_key),
    .upd_q     (div_q),
    .upd_r     (div_r)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      opnd_key   <= '0;
      opnd_mod   <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      div_start  <= 1'b0;
    end else begin
      div_start <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          opnd_key <= lookup_key;
          opnd_mod <= in_op[0];
          if (hit) begin
            out_result <= in_op[0] ? cache_r : cache_q;
            out_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            div_start <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: if (div_done) begin
          if (flush) begin
            state <= IDLE;
          end else begin
            out_result <= opnd_mod ? div_r : div_q;
            out_valid  <= 1'b1;
            state      <= RESP;
          end
        end else if (flush) begin
          state <= DRAIN;
        end
        DRAIN: if (div_done) state <= IDLE;
        RESP: if (flush || out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural multi-cycle divider beside it.
module tb_div_ctrl;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_x = '0, in_y = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_result;
  logic        flush = 1'b0;
  logic        div_start, div_signed;
  logic [31:0] div_x, div_y;
  logic        div_busy, div_done;
  logic [31:0] div_q, div_r;

  int checks = 0, errors = 0, starts = 0;
  int cnt;

  div_ctrl #(.CACHE_EN(1'b1)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .flush(flush),
    .div_start(div_start), .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
    .div_busy(div_busy), .div_done(div_done), .div_q(div_q), .div_r(div_r)
  );

  always #5 clk = ~clk;

  // Divider model: operands and sign mode are read again at completion,
  // so any instability between launch and done corrupts the result.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_busy <= 1'b0; div_done <= 1'b0; div_q <= '0; div_r <= '0; cnt <= 0;
    end else begin
      div_done <= 1'b0;
      if (div_start) begin
        div_busy <= 1'b1; cnt <= 6;
      end else if (div_busy) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          div_busy <= 1'b0;
          div_done <= 1'b1;
          if (div_signed) begin
            div_q <= $signed(div_x) / $signed(div_y);
            div_r <= $signed(div_x) % $signed(div_y);
          end else begin
            div_q <= div_x / div_y;
            div_r <= div_x % div_y;
          end
        end
      end
    end
  end

  always @(posedge clk) if (div_start) starts++;

  always @(negedge clk) if (resetn && div_start) begin
    checks++;
    assert (div_busy === 1'b0) else begin
      errors++; $error("FAIL start_while_busy got %b exp 0", div_busy);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++; $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    in_valid = 1'b1; in_op = op; in_x = x; in_y = y;
    chk("in_ready_pre", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!div_done && n < 50) begin tick(); n++; end
    chk(tag, {31'b0, div_done}, 32'd1);
  endtask

  task automatic run_miss(input string tag, input logic [1:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp);
    int s0 = starts;
    send(op, x, y);
    chk({tag, "_start"}, {31'b0, div_start}, 32'd1);
    chk({tag, "_noval"}, {31'b0, out_valid}, 32'd0);
    wait_done({tag, "_done"});
    tick();
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_res"}, out_result, exp);
    tick();
    chk({tag, "_clr"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_nstart"}, starts, s0 + 1);
  endtask

  task automatic run_hit(input string tag, input logic [1:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp);
    int s0 = starts;
    send(op, x, y);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_res"}, out_result, exp);
    chk({tag, "_nostart"}, {31'b0, div_start}, 32'd0);
    tick();
    chk({tag, "_clr"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_nstart"}, starts, s0);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_cache", {31'b0, dut.u_cache.valid}, 32'd0);
    resetn = 1'b1;
    tick();

    run_miss("divw", OP_DIV_W, 32'd100, 32'd7, 32'd14);
    run_hit("modw", OP_MOD_W, 32'd100, 32'd7, 32'd2);
    run_miss("divw_neg", OP_DIV_W, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_hit("modw_neg", OP_MOD_W, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_miss("divwu", OP_DIV_WU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF);
    run_hit("modwu", OP_MOD_WU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F);
    run_miss("divw_sgn", OP_DIV_W, 32'hFFFF_FFFF, 32'h10, 32'h0000_0000);

    flush = 1'b1; #1;
    chk("idle_flush_blocks", {31'b0, in_ready}, 32'd0);
    flush = 1'b0; #1;

    // Flush five cycles into the division: result is drained, cache still fills.
    send(OP_DIV_W, 32'd1000, 32'd3);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("drain_in_ready", {31'b0, in_ready}, 32'd0);
    wait_done("drain_done");
    chk("drain_in_ready2", {31'b0, in_ready}, 32'd0);
    tick();
    chk("drain_noval", {31'b0, out_valid}, 32'd0);
    chk("drain_idle", {31'b0, in_ready}, 32'd1);
    run_hit("drain_hit", OP_MOD_W, 32'd1000, 32'd3, 32'd1);

    // Backpressure in RESP.
    out_ready = 1'b0;
    send(OP_DIV_W, 32'd50, 32'd5);
    wait_done("bp_done");
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_res", out_result, 32'd10);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_clr", {31'b0, out_valid}, 32'd0);

    // Reset in the middle of a division.
    send(OP_DIV_W, 32'd9, 32'd2);
    tick();
    resetn = 1'b0; #1;
    chk("mrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mrst_out_result", out_result, 32'd0);
    chk("mrst_start", {31'b0, div_start}, 32'd0);
    chk("mrst_signed", {31'b0, div_signed}, 32'd0);
    chk("mrst_x", div_x, 32'd0);
    chk("mrst_y", div_y, 32'd0);
    chk("mrst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("mrst_cache", {31'b0, dut.u_cache.valid}, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    run_miss("post_rst", OP_DIV_W, 32'd50, 32'd5, 32'd10);
    run_hit("post_rst_hit", OP_MOD_W, 32'd50, 32'd5, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing controller between the EX stage and the 32-bit multi-cycle divider.
- Accepts DIV.W / MOD.W / DIV.WU / MOD.WU requests over a valid/ready handshake and launches the divider.
- Holds divider operands and mode stable until completion, then selects quotient or remainder and presents it on an output valid/ready handshake.
- Handles pipeline flush without aborting the divider, and keeps a one-entry result cache so a DIV/MOD pair on the same operands costs one division.

Parameters:
- CACHE_EN, 1: 1 = one-entry operand/result cache enabled; 0 = every request launches the divider.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready at posedge
- in_op  in  2  00 DIV.W, 01 MOD.W, 10 DIV.WU, 11 MOD.WU
- in_x  in  32  dividend
- in_y  in  32  divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  32  quotient (DIV) or remainder (MOD)
- flush  in  1  cancel request in flight or pending
- div_start  out  1  divider launch pulse
- div_signed  out  1  divider signed mode
- div_x  out  32  divider dividend
- div_y  out  32  divider divisor
- div_busy  in  1  divider busy
- div_done  in  1  divider done pulse; div_q/div_r valid in this cycle
- div_q  in  32  divider quotient
- div_r  in  32  divider remainder

Behaviour:
- Reset values: state=IDLE, in_ready=0 during reset, out_valid=0, out_result=0, div_start=0, div_signed=0, div_x=0, div_y=0, cache_valid=0.
- States: IDLE, WAIT, RESP, DRAIN. All outputs except in_ready are registered.
- in_ready = (state==IDLE) & !flush. A flush in IDLE blocks acceptance.
- Operand registers: opnd_x, opnd_y, opnd_signed = ~in_op[1], opnd_mod = in_op[0]. They load on acceptance.
  - div_x, div_y and div_signed are driven from these registers.
  - They must stay stable from launch through the div_done cycle, because the divider samples the sign mode again at completion.
- Cache: cache_valid, cache_x, cache_y, cache_signed, cache_q, cache_r.
  - Hit = CACHE_EN & cache_valid & (in_x==cache_x) & (in_y==cache_y) & (signed==cache_signed).
  - The op select bit (DIV/MOD) does not participate in the match.
- IDLE, accept and hit: load out_result with cache_q or cache_r, set out_valid=1, go to RESP. Latency is 1 cycle and div_start is not pulsed.
- IDLE, accept and miss: div_start=1 for exactly one cycle (the cycle after acceptance), go to WAIT.
- WAIT, div_done:
  - Update the cache with (opnd_x, opnd_y, opnd_signed, div_q, div_r) and set cache_valid=1.
  - Load out_result with div_q or div_r per opnd_mod, set out_valid=1, go to RESP.
  - If flush is high in the same cycle, go to IDLE instead: the cache is still updated, out_valid stays 0.
- WAIT, flush without div_done: go to DRAIN.
- DRAIN: in_ready=0. On div_done, update the cache, discard the result and go to IDLE. A flush in DRAIN has no further effect.
- RESP: out_valid and out_result are held until out_ready, then out_valid=0 and the state goes to IDLE.
  - No new request is accepted in the same cycle the result is accepted.
  - Flush in RESP: out_valid=0, go to IDLE, result dropped.
- Divide by zero: launched normally; the divider output is passed through unchecked. This is architecturally undefined in LoongArch.
- Reset mid-operation: the controller returns to IDLE with the cache invalidated. The divider is reset by the same system reset through its own active-high port at top level.
- div_start is never asserted while div_busy=1. The state machine guarantees this, and the bench checks it with an assertion.

Decomposition:
- Shared package div_pkg holds:
  - op encodings: OP_DIV_W=2'b00, OP_MOD_W=2'b01, OP_DIV_WU=2'b10, OP_MOD_WU=2'b11;
  - the state enum: IDLE, WAIT, RESP, DRAIN.
- One sub-module, div_result_cache: a single-entry store with a match output, an update port and an invalidate input.
- The FSM and handshakes stay in div_ctrl. The divider is instantiated beside div_ctrl at the EX stage, not inside it.

Test Plan:
- DIV.W x=100, y=7, out_ready=1 -> one div_start pulse; out_result=14 one cycle after div_done.
- Follow-up MOD.W x=100, y=7 -> no div_start; out_valid the cycle after acceptance; out_result=2.
- DIV.W x=-7 (0xFFFFFFF9), y=2 -> 0xFFFFFFFD; then MOD.W on the same operands -> 0xFFFFFFFF from cache.
- DIV.WU x=0xFFFFFFFF, y=0x10 -> 0x0FFFFFFF; then MOD.WU x=0xFFFFFFFF, y=0x10 -> 0x0000000F; then the same operands as DIV.W -> miss (sign differs), div_start pulses, out_result=0.
- Flush 5 cycles after launch -> DRAIN, in_ready=0 until div_done, no out_valid; next request MOD.W on the same operands is a cache hit.
- Hold out_ready=0 for 10 cycles in RESP -> out_valid and out_result stable, in_ready=0. Assert resetn low mid-WAIT -> all outputs at reset values and cache_valid=0.
